// File: rtl/vga_pkg.sv
// Shared 640x480 raster timing constants and the pixel coordinate types used by
// vga_sync_generator and pixel_receiver.
package vga_pkg;

  localparam int unsigned H_VISIBLE   = 640;
  localparam int unsigned H_FRONT     = 16;
  localparam int unsigned H_SYNC      = 96;
  localparam int unsigned H_BACK      = 48;
  localparam int unsigned H_TOTAL     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE   = 480;
  localparam int unsigned V_FRONT     = 10;
  localparam int unsigned V_SYNC      = 2;
  localparam int unsigned V_BACK      = 33;
  localparam int unsigned V_TOTAL     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned WIDTH_BITS  = 10;
  localparam int unsigned HEIGHT_BITS = 9;
  localparam int unsigned PIXEL_BITS  = 12;
  localparam int unsigned COUNT_BITS  = 10;

  localparam logic SYNC_ACTIVE = 1'b0;

  typedef logic [WIDTH_BITS-1:0]  pixel_x_t;
  typedef logic [HEIGHT_BITS-1:0] pixel_y_t;
  typedef logic [COUNT_BITS-1:0]  count_t;

  // Inclusive window test on raster counters.
  function automatic logic in_window(input count_t val, input count_t lo, input count_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_generator_if.sv
// Raster timing bundle between the sync generator (master) and its consumer (slave).
interface vga_sync_generator_if;
  import vga_pkg::*;

  logic     pixel_enable_in;
  logic     h_sync_out;
  logic     v_sync_out;
  logic     video_on_out;
  pixel_x_t pixel_x_out;
  pixel_y_t pixel_y_out;
  logic     frame_start_out;
  logic     line_end_out;

  modport master (
    input  pixel_enable_in,
    output h_sync_out, v_sync_out, video_on_out,
           pixel_x_out, pixel_y_out, frame_start_out, line_end_out
  );

  modport slave (
    output pixel_enable_in,
    input  h_sync_out, v_sync_out, video_on_out,
           pixel_x_out, pixel_y_out, frame_start_out, line_end_out
  );
endinterface

// File: rtl/mod_counter.sv
// Enable-gated modulo counter; wrap_o flags the enabled edge that returns it to zero.
module mod_counter #(
  parameter int unsigned MODULUS = 800,
  parameter int unsigned WIDTH   = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    wrap_o  = en_i && (count_q == LAST);
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/vga_sync_generator.sv
// VGA raster timing generator: registers the decode of the current (h,v) on each
// pixel tick, so outputs trail the counters by one enabled edge.
module vga_sync_generator #(
  parameter int unsigned H_VISIBLE   = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT     = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC      = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK      = vga_pkg::H_BACK,
  parameter int unsigned V_VISIBLE   = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT     = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC      = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK      = vga_pkg::V_BACK,
  parameter logic        SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE
) (
  input  logic                 clock_in,
  input  logic                 reset_n_in,
  vga_sync_generator_if.master timing
);
  import vga_pkg::*;

  localparam int unsigned LINE_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam count_t H_VIS_C   = count_t'(H_VISIBLE);
  localparam count_t HS_FIRST  = count_t'(H_VISIBLE + H_FRONT);
  localparam count_t HS_LAST   = count_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam count_t H_LAST_C  = count_t'(LINE_TOTAL - 1);
  localparam count_t V_VIS_C   = count_t'(V_VISIBLE);
  localparam count_t VS_FIRST  = count_t'(V_VISIBLE + V_FRONT);
  localparam count_t VS_LAST   = count_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  count_t h_count, v_count;
  logic   h_wrap, v_wrap;

  mod_counter #(.MODULUS(LINE_TOTAL), .WIDTH(COUNT_BITS)) u_h_counter (
    .clk_i   (clock_in),
    .rst_ni  (reset_n_in),
    .en_i    (timing.pixel_enable_in),
    .count_o (h_count),
    .wrap_o  (h_wrap)
  );

  mod_counter #(.MODULUS(FRAME_LINES), .WIDTH(COUNT_BITS)) u_v_counter (
    .clk_i   (clock_in),
    .rst_ni  (reset_n_in),
    .en_i    (timing.pixel_enable_in && h_wrap),
    .count_o (v_count),
    .wrap_o  (v_wrap)
  );

  logic     h_sync_q, h_sync_d;
  logic     v_sync_q, v_sync_d;
  logic     video_on_q, video_on_d;
  pixel_x_t pixel_x_q, pixel_x_d;
  pixel_y_t pixel_y_q, pixel_y_d;
  logic     frame_start_q, frame_start_d;
  logic     line_end_q, line_end_d;
  logic     visible;

  always_comb begin
    visible       = (h_count < H_VIS_C) && (v_count < V_VIS_C);
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    video_on_d    = video_on_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    // Pulses drop on every clock that is not an enabled edge.
    frame_start_d = 1'b0;
    line_end_d    = 1'b0;
    if (timing.pixel_enable_in) begin
      h_sync_d      = in_window(h_count, HS_FIRST, HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      v_sync_d      = in_window(v_count, VS_FIRST, VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on_d    = visible;
      pixel_x_d     = visible ? pixel_x_t'(h_count) : '0;
      pixel_y_d     = visible ? pixel_y_t'(v_count) : '0;
      frame_start_d = (h_count == '0) && (v_count == '0);
      line_end_d    = (h_count == H_LAST_C);
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      h_sync_q      <= ~SYNC_ACTIVE;
      v_sync_q      <= ~SYNC_ACTIVE;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      frame_start_q <= 1'b0;
      line_end_q    <= 1'b0;
    end else begin
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      frame_start_q <= frame_start_d;
      line_end_q    <= line_end_d;
    end
  end

  // The vertical counter may only roll over on the same edge as the horizontal one.
  a_v_wrap_on_h_wrap: assert property (@(posedge clock_in) disable iff (!reset_n_in)
    v_wrap |-> h_wrap);

  assign timing.h_sync_out      = h_sync_q;
  assign timing.v_sync_out      = v_sync_q;
  assign timing.video_on_out    = video_on_q;
  assign timing.pixel_x_out     = pixel_x_q;
  assign timing.pixel_y_out     = pixel_y_q;
  assign timing.frame_start_out = frame_start_q;
  assign timing.line_end_out    = line_end_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: full-size instance for reset/line/enable/reset-mid-line,
// reduced-timing instance for whole-frame behaviour.
module tb_vga_sync_generator;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_n_s;

  vga_sync_generator_if vif ();
  vga_sync_generator_if sif ();

  vga_sync_generator u_dut (
    .clock_in   (clk),
    .reset_n_in (rst_n),
    .timing     (vif)
  );

  // Small raster: line = 8+2+3+2 = 15, frame = 4+1+2+1 = 8 lines, 120 edges.
  vga_sync_generator #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_small (
    .clock_in   (clk),
    .reset_n_in (rst_n_s),
    .timing     (sif)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic hs, input logic vs, input logic von,
                            input int x, input int y, input logic fs, input logic le);
    check($sformatf("%s.h_sync", tag),      int'(vif.h_sync_out),      int'(hs));
    check($sformatf("%s.v_sync", tag),      int'(vif.v_sync_out),      int'(vs));
    check($sformatf("%s.video_on", tag),    int'(vif.video_on_out),    int'(von));
    check($sformatf("%s.x", tag),           int'(vif.pixel_x_out),     x);
    check($sformatf("%s.y", tag),           int'(vif.pixel_y_out),     y);
    check($sformatf("%s.frame_start", tag), int'(vif.frame_start_out), int'(fs));
    check($sformatf("%s.line_end", tag),    int'(vif.line_end_out),    int'(le));
  endtask

  function automatic logic [23:0] snap();
    return {vif.h_sync_out, vif.v_sync_out, vif.video_on_out, vif.pixel_x_out,
            vif.pixel_y_out, vif.frame_start_out, vif.line_end_out};
  endfunction

  typedef struct {
    logic rst_n;
    logic pe;
    logic hs, vs, von;
    int   x, y;
    logic fs, le;
  } vec_t;

  vec_t        vecs[8];
  logic [23:0] line_rec[1:800];

  initial begin
    int von_cnt, von_last, hs_cnt, hs_first, hs_last, le_cnt, le_edge, fs_cnt;
    int e, mism, pulse_bad, hold_bad;
    logic [23:0] prev, cur;

    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2, 0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3, 0, 1'b0, 1'b0};

    rst_n = 1'b0;
    rst_n_s = 1'b0;
    vif.pixel_enable_in = 1'b1;
    sif.pixel_enable_in = 1'b1;

    // Reset, release and first few pixel ticks with the enable gapped.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      vif.pixel_enable_in = vecs[i].pe;
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].hs, vecs[i].vs, vecs[i].von,
                 vecs[i].x, vecs[i].y, vecs[i].fs, vecs[i].le);
    end

    // One full line with the enable tied high; edge k presents h = k-1.
    @(negedge clk); rst_n = 1'b0; vif.pixel_enable_in = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    von_cnt = 0; von_last = 0; hs_cnt = 0; hs_first = 0; hs_last = 0;
    le_cnt = 0; le_edge = 0; fs_cnt = 0;
    for (int k = 1; k <= 800; k++) begin
      @(posedge clk);
      #1;
      line_rec[k] = snap();
      if (vif.video_on_out) begin von_cnt++; von_last = k; end
      if (!vif.h_sync_out) begin
        if (hs_cnt == 0) hs_first = k;
        hs_cnt++;
        hs_last = k;
      end
      if (vif.line_end_out) begin le_cnt++; le_edge = k; end
      if (vif.frame_start_out) fs_cnt++;
    end
    check("line.video_on_edges", von_cnt, 640);
    check("line.video_on_last", von_last, 640);
    check("line.hsync_edges", hs_cnt, 96);
    check("line.hsync_first", hs_first, 657);
    check("line.hsync_last", hs_last, 752);
    check("line.line_end_pulses", le_cnt, 1);
    check("line.line_end_edge", le_edge, 800);
    check("line.frame_start_pulses", fs_cnt, 1);
    @(posedge clk);
    #1;
    check_outs("line1_start", 1'b1, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0);

    // Enable on every other clock must reproduce the same per-tick sequence.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; vif.pixel_enable_in = 1'b0;
    @(posedge clk);
    #1;
    prev = snap();
    e = 0; mism = 0; pulse_bad = 0; hold_bad = 0;
    for (int c = 0; c < 1600; c++) begin
      @(negedge clk);
      vif.pixel_enable_in = (c % 2 == 0);
      @(posedge clk);
      #1;
      cur = snap();
      if (vif.pixel_enable_in) begin
        e++;
        if (cur != line_rec[e]) mism++;
      end else begin
        if (vif.frame_start_out || vif.line_end_out) pulse_bad++;
        if (cur[23:2] != prev[23:2]) hold_bad++;
      end
      prev = cur;
    end
    check("gapped.enabled_edges", e, 800);
    check("gapped.sequence_mismatches", mism, 0);
    check("gapped.pulse_not_cleared", pulse_bad, 0);
    check("gapped.level_not_held", hold_bad, 0);

    // Asynchronous reset inside the horizontal sync window of line 1.
    @(negedge clk); rst_n = 1'b0; vif.pixel_enable_in = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (1500) @(posedge clk);
    #1;
    check_outs("pre_reset", 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs("restart", 1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0);

    // Reduced raster: two frames plus one edge against a raster model.
    begin
      int h, v, exp_x, exp_y, fs_edges, fs_prev, fs_gap, vs_cnt, vs_first;
      logic exp_von, exp_hs, exp_vs, exp_fs, exp_le;
      mism = 0; von_cnt = 0; vs_cnt = 0; vs_first = 0;
      fs_edges = 0; fs_prev = 0; fs_gap = 0;
      @(negedge clk); rst_n_s = 1'b1;
      for (int k = 1; k <= 241; k++) begin
        @(posedge clk);
        #1;
        h = (k - 1) % 15;
        v = ((k - 1) / 15) % 8;
        exp_von = (h < 8) && (v < 4);
        exp_hs  = !((h >= 10) && (h <= 12));
        exp_vs  = !((v >= 5) && (v <= 6));
        exp_x   = exp_von ? h : 0;
        exp_y   = exp_von ? v : 0;
        exp_fs  = (h == 0) && (v == 0);
        exp_le  = (h == 14);
        if (sif.video_on_out !== exp_von || sif.h_sync_out !== exp_hs ||
            sif.v_sync_out !== exp_vs || int'(sif.pixel_x_out) != exp_x ||
            int'(sif.pixel_y_out) != exp_y || sif.frame_start_out !== exp_fs ||
            sif.line_end_out !== exp_le) mism++;
        if (k <= 120) begin
          if (sif.video_on_out) von_cnt++;
          if (!sif.v_sync_out) begin
            if (vs_cnt == 0) vs_first = k;
            vs_cnt++;
          end
        end
        if (sif.frame_start_out) begin
          if (fs_edges > 0) fs_gap = k - fs_prev;
          fs_edges++;
          fs_prev = k;
        end
      end
      check("frame.raster_mismatches", mism, 0);
      check("frame.video_on_edges", von_cnt, 32);
      check("frame.vsync_edges", vs_cnt, 30);
      check("frame.vsync_first", vs_first, 76);
      check("frame.frame_start_pulses", fs_edges, 3);
      check("frame.frame_start_period", fs_gap, 120);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
